// File: rtl/riscv_core_rv32i.sv
// Multicycle RV32I core with Harvard ports and 2-cycle-latency synchronous RAMs.
// A step input gates each instruction start so a controller can throttle or single-step.
module riscv_core_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_step_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] imem_addr_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_data_out,
    output logic [3:0]  dmem_write_enable_out,
    input  logic [31:0] dmem_data_in
);
    // state   | meaning
    // FETCH   | PC on imem bus; waits for cpu_step_in
    // WAIT    | instruction RAM latency
    // EXEC    | decode/execute; stores strobe here; non-loads retire
    // LD_WAIT | data RAM latency
    // LD_WB   | load data extracted and written back
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_LD_WAIT = 3'd3;
    localparam logic [2:0] S_LD_WB   = 3'd4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] regs [32];
    logic [31:0] ld_addr;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_f3;

    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_out, ea, pc_plus4;
    logic [4:0]  shamt;
    logic        is_op, is_load, is_store, br_taken;
    logic        wb_en;
    logic [31:0] wb_val, next_pc;
    logic [31:0] st_data, ld_val;
    logic [3:0]  st_strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ir       = imem_data_in;
    assign opcode   = ir[6:0];
    assign rd       = ir[11:7];
    assign f3       = ir[14:12];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign imm_i    = {{20{ir[31]}}, ir[31:20]};
    assign imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u    = {ir[31:12], 12'b0};
    assign imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign rs1_val  = regs[rs1];
    assign rs2_val  = regs[rs2];
    assign is_op    = (opcode == OPC_OP);
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign alu_b    = is_op ? rs2_val : imm_i;
    assign shamt    = alu_b[4:0];
    assign ea       = rs1_val + (is_store ? imm_s : imm_i);
    assign pc_plus4 = pc + 32'd4;
    assign imem_addr_out = pc;

    always_comb begin
        case (f3)
            3'd0:    alu_out = (is_op && ir[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1:    alu_out = rs1_val << shamt;
            3'd2:    alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'd3:    alu_out = {31'b0, rs1_val < alu_b};
            3'd4:    alu_out = rs1_val ^ alu_b;
            3'd5:    alu_out = ir[30] ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'd6:    alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'd0:    br_taken = (rs1_val == rs2_val);
            3'd1:    br_taken = (rs1_val != rs2_val);
            3'd4:    br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    br_taken = (rs1_val < rs2_val);
            3'd7:    br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_val  = alu_out;
        next_pc = pc_plus4;
        case (opcode)
            OPC_LUI:    begin wb_en = 1'b1; wb_val = imm_u; end
            OPC_AUIPC:  begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OPC_JAL:    begin wb_en = 1'b1; wb_val = pc_plus4; next_pc = pc + imm_j; end
            OPC_JALR:   begin wb_en = 1'b1; wb_val = pc_plus4; next_pc = (rs1_val + imm_i) & ~32'd1; end
            OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
            OPC_OP_IMM: wb_en = 1'b1;
            OPC_OP:     wb_en = 1'b1;
            default:    wb_en = 1'b0;
        endcase
    end

    always_comb begin
        st_data = '0;
        st_strb = '0;
        case (f3)
            3'd0:    begin st_data = {4{rs2_val[7:0]}};  st_strb = 4'b0001 << ea[1:0]; end
            3'd1:    begin st_data = {2{rs2_val[15:0]}}; st_strb = 4'b0011 << {ea[1], 1'b0}; end
            3'd2:    begin st_data = rs2_val;            st_strb = 4'b1111; end
            default: begin st_data = '0;                 st_strb = 4'b0000; end
        endcase
    end

    always_comb begin
        case (ld_addr[1:0])
            2'd0:    ld_byte = dmem_data_in[7:0];
            2'd1:    ld_byte = dmem_data_in[15:8];
            2'd2:    ld_byte = dmem_data_in[23:16];
            default: ld_byte = dmem_data_in[31:24];
        endcase
        ld_half = ld_addr[1] ? dmem_data_in[31:16] : dmem_data_in[15:0];
        case (ld_f3)
            3'd0:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_val = {24'b0, ld_byte};
            3'd5:    ld_val = {16'b0, ld_half};
            default: ld_val = dmem_data_in;
        endcase
    end

    // Strobe is gated by rst_in combinationally so a reset mid-store never writes.
    always_comb begin
        dmem_addr_out         = '0;
        dmem_data_out         = '0;
        dmem_write_enable_out = '0;
        case (state)
            S_EXEC: begin
                if (is_store) begin
                    dmem_addr_out         = {ea[31:2], 2'b00};
                    dmem_data_out         = st_data;
                    dmem_write_enable_out = rst_in ? 4'b0000 : st_strb;
                end else if (is_load) begin
                    dmem_addr_out = {ea[31:2], 2'b00};
                end
            end
            S_LD_WAIT, S_LD_WB: dmem_addr_out = {ld_addr[31:2], 2'b00};
            default: dmem_addr_out = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ld_addr <= '0;
            ld_rd   <= '0;
            ld_f3   <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (cpu_step_in) state <= S_WAIT;
                S_WAIT:  state <= S_EXEC;
                S_EXEC: begin
                    if (is_load) begin
                        ld_addr <= ea;
                        ld_rd   <= rd;
                        ld_f3   <= f3;
                        state   <= S_LD_WAIT;
                    end else begin
                        pc <= next_pc;
                        if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
                        state <= S_FETCH;
                    end
                end
                S_LD_WAIT: state <= S_LD_WB;
                S_LD_WB: begin
                    if (ld_rd != 5'd0) regs[ld_rd] <= ld_val;
                    pc    <= pc_plus4;
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_core_rv32i.sv
// Directed bench for riscv_core_rv32i: models both 2-cycle RAMs, scoreboards store
// transactions, and checks architectural state against hand-derived values.
module tb_riscv_core_rv32i;
    logic        clk_in = 1'b0;
    logic        rst_in, cpu_step_in;
    logic [31:0] imem_data_in, imem_addr_out, dmem_addr_out, dmem_data_out, dmem_data_in;
    logic [3:0]  dmem_write_enable_out;

    always #5 clk_in = ~clk_in;

    riscv_core_rv32i #(.RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_step_in(cpu_step_in),
        .imem_data_in(imem_data_in), .imem_addr_out(imem_addr_out),
        .dmem_addr_out(dmem_addr_out), .dmem_data_out(dmem_data_out),
        .dmem_write_enable_out(dmem_write_enable_out), .dmem_data_in(dmem_data_in)
    );

    localparam logic [31:0] OPI  = 32'h13, LOAD = 32'h03, LUI = 32'h37, AUIPC = 32'h17, JALR = 32'h67;
    localparam logic [31:0] NOP  = 32'h13;

    logic [31:0] imem [64];
    logic [31:0] dmem [1024];
    logic        dmem_clear;
    logic [5:0]  imem_a_q;
    logic [9:0]  dmem_a_q;

    always @(posedge clk_in) begin
        imem_a_q     <= imem_addr_out[7:2];
        imem_data_in <= imem[imem_a_q];
    end

    always @(posedge clk_in) begin
        dmem_a_q     <= dmem_addr_out[11:2];
        dmem_data_in <= dmem[dmem_a_q];
        if (dmem_clear) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (dmem_write_enable_out[b]) dmem[dmem_addr_out[11:2]][8*b +: 8] <= dmem_data_out[8*b +: 8];
        end
    end

    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } st_t;
    st_t sb_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_regs [32];

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] f3, input logic [31:0] rd, input logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2, input logic [31:0] rs1, input logic [31:0] f3, input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2, input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2, input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd, input logic [31:0] op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic sb_check();
        st_t e;
        if (dmem_write_enable_out !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {28'b0, dmem_write_enable_out}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("st_addr", dmem_addr_out, e.addr);
                chk("st_data", dmem_data_out, e.data);
                chk("st_strobe", {28'b0, dmem_write_enable_out}, {28'b0, e.strb});
            end
        end
    endtask

    task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        st_t e;
        e.addr = a; e.data = d; e.strb = s;
        sb_q.push_back(e);
    endtask

    // One clock: sample mid-cycle, then step past the next rising edge.
    task automatic tick();
        @(negedge clk_in);
        sb_check();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; dmem_clear = 1'b1;
        tick();
        rst_in = 1'b0; dmem_clear = 1'b0;
    endtask

    task automatic run_instr(input int len, input bit rnd);
        if (rnd) begin
            cpu_step_in = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        cpu_step_in = 1'b1;
        tick();
        repeat (len - 1) begin
            cpu_step_in = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            tick();
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    task automatic load_prog1();
        clear_imem();
        imem[0]  = enc_i(5, 0, 0, 1, OPI);
        imem[1]  = enc_i(-7, 1, 0, 2, OPI);
        imem[2]  = enc_u(32'h1, 5, LUI);
        imem[3]  = enc_u(32'hA1B2C, 6, LUI);
        imem[4]  = enc_i(32'h3D4, 6, 0, 6, OPI);
        imem[5]  = enc_s(1, 6, 5, 0);
        imem[6]  = enc_s(2, 6, 5, 1);
        imem[7]  = enc_i(0, 5, 2, 7, LOAD);
        imem[8]  = enc_i(1, 5, 0, 8, LOAD);
        imem[9]  = enc_i(1, 5, 4, 9, LOAD);
        imem[10] = enc_i(2, 5, 1, 10, LOAD);
        imem[11] = enc_i(2, 5, 5, 11, LOAD);
        imem[12] = enc_i(-1, 0, 0, 12, OPI);
        imem[13] = enc_i(1, 0, 0, 13, OPI);
        imem[14] = enc_b(8, 13, 12, 6);
        imem[15] = enc_r(0, 13, 12, 2, 14);
        imem[16] = enc_r(0, 13, 12, 3, 15);
        imem[17] = enc_r(0, 13, 12, 0, 16);
        imem[18] = enc_u(32'h80000, 17, LUI);
        imem[19] = enc_i(31, 0, 0, 18, OPI);
        imem[20] = enc_r(32'h20, 18, 17, 5, 19);
        imem[21] = enc_i(7, 0, 0, 0, OPI);
        imem[22] = enc_r(32'h20, 12, 13, 0, 20);
        imem[23] = enc_i(32'h404, 17, 5, 21, OPI);
        imem[24] = enc_i(4, 17, 5, 22, OPI);
        imem[25] = enc_s(4, 6, 5, 2);
        imem[26] = enc_j(12, 23);
        imem[27] = enc_i(99, 0, 0, 24, OPI);
        imem[28] = enc_i(98, 0, 0, 24, OPI);
        imem[29] = enc_u(32'h1, 25, AUIPC);
        imem[30] = enc_j(0, 0);
    endtask

    // Executes program 1 along its known path: 0..104 linearly, then the jump target 116.
    task automatic run_prog1(input bit rnd);
        logic [31:0] p, np;
        int len;
        for (int k = 0; k < 28; k++) begin
            p   = (k < 27) ? 32'(4 * k) : 32'd116;
            np  = (k < 26) ? p + 32'd4 : ((k == 26) ? 32'd116 : 32'd120);
            len = (p >= 28 && p <= 44) ? 5 : 3;
            if (p == 20)  push_st(32'h1000, 32'hD4D4D4D4, 4'b0010);
            if (p == 24)  push_st(32'h1000, 32'hC3D4C3D4, 4'b1100);
            if (p == 100) push_st(32'h1004, 32'hA1B2C3D4, 4'b1111);
            run_instr(len, rnd);
            if (!rnd) chk($sformatf("pc_after_%0d", p), dut.pc, np);
            if (!rnd && p == 4) begin
                chk("x1_addi", dut.regs[1], 32'd5);
                chk("x2_addi_neg", dut.regs[2], 32'hFFFFFFFE);
            end
        end
        for (int i = 0; i < 32; i++) chk($sformatf("x%0d_final", i), dut.regs[i], exp_regs[i]);
        chk("pc_final", dut.pc, 32'd120);
        chk("mem_1000", dmem[0], 32'hC3D4D400);
        chk("mem_1004", dmem[1], 32'hA1B2C3D4);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst_in = 1'b1; cpu_step_in = 1'b0; dmem_clear = 1'b1;
        for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
        exp_regs[1]  = 32'd5;        exp_regs[2]  = 32'hFFFFFFFE; exp_regs[5]  = 32'h1000;
        exp_regs[6]  = 32'hA1B2C3D4; exp_regs[7]  = 32'hC3D4D400; exp_regs[8]  = 32'hFFFFFFD4;
        exp_regs[9]  = 32'h000000D4; exp_regs[10] = 32'hFFFFC3D4; exp_regs[11] = 32'h0000C3D4;
        exp_regs[12] = 32'hFFFFFFFF; exp_regs[13] = 32'd1;        exp_regs[14] = 32'd1;
        exp_regs[17] = 32'h80000000; exp_regs[18] = 32'd31;       exp_regs[19] = 32'hFFFFFFFF;
        exp_regs[20] = 32'd2;        exp_regs[21] = 32'hF8000000; exp_regs[22] = 32'h08000000;
        exp_regs[23] = 32'd108;      exp_regs[25] = 32'h1074;

        // Program 1 with step held low first, then free-running.
        load_prog1();
        do_reset();
        chk("rst_imem_addr", imem_addr_out, 32'h0);
        chk("rst_we", {28'b0, dmem_write_enable_out}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gate_pc", imem_addr_out, 32'h0);
            chk("gate_we", {28'b0, dmem_write_enable_out}, 32'h0);
        end
        run_prog1(1'b0);

        // Same program under random step gating must land in the same state.
        do_reset();
        run_prog1(1'b1);

        // Taken backward branch plus ignored system ops.
        clear_imem();
        imem[0] = NOP; imem[1] = NOP;
        imem[2] = enc_i(1, 3, 0, 3, OPI);
        imem[3] = 32'h00000073;
        imem[4] = enc_b(-8, 0, 0, 0);
        do_reset();
        repeat (5) run_instr(3, 1'b0);
        chk("beq_pc", dut.pc, 32'd8);
        chk("beq_x3", dut.regs[3], 32'd1);
        repeat (3) run_instr(3, 1'b0);
        chk("beq_loop_pc", dut.pc, 32'd8);
        chk("beq_loop_x3", dut.regs[3], 32'd2);

        // JALR to a misaligned target, then execution continues from the aliased word.
        clear_imem();
        imem[0] = NOP; imem[1] = NOP; imem[2] = NOP; imem[3] = NOP;
        imem[4] = 32'h0000000F;
        imem[5] = enc_i(3, 0, 0, 1, JALR);
        do_reset();
        repeat (6) run_instr(3, 1'b0);
        chk("jalr_pc", dut.pc, 32'd2);
        chk("jalr_link", dut.regs[1], 32'd24);
        run_instr(3, 1'b0);
        chk("misaligned_pc", dut.pc, 32'd6);

        // Reset during the EXEC cycle of a store.
        clear_imem();
        imem[0] = enc_u(32'h1, 5, LUI);
        imem[1] = enc_i(32'h55, 0, 0, 6, OPI);
        imem[2] = enc_s(0, 6, 5, 2);
        do_reset();
        repeat (2) run_instr(3, 1'b0);
        chk("pre_x6", dut.regs[6], 32'h55);
        cpu_step_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b1;
        #1;
        chk("rst_mid_store_we", {28'b0, dmem_write_enable_out}, 32'h0);
        tick();
        rst_in = 1'b0;
        chk("rst_mid_pc", dut.pc, 32'h0);
        chk("rst_mid_x5", dut.regs[5], 32'h0);
        chk("rst_mid_x6", dut.regs[6], 32'h0);
        chk("rst_mid_mem", dmem[0], 32'h0);
        chk("sb_drained_end", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_core_rv32i.md
# riscv_core_rv32i

Multicycle, non-pipelined RV32I integer core with Harvard memory ports. It fetches from a read-only instruction RAM and loads/stores to a byte-writable data RAM; both RAMs are synchronous with a fixed 2-cycle read latency (address register plus output register). A step-enable input gates the start of each instruction, so an external controller can single-step or throttle the CPU.

## Interface
- RESET_PC, default 32'h0000_0000: PC value after reset.
- clk_in  in  1  system clock; all state updates on the rising edge.
- rst_in  in  1  one clock; reset is synchronous and active-high.
- cpu_step_in  in  1  when 1 in FETCH, the next instruction starts; when 0 the core idles in FETCH.
- imem_data_in  in  32  instruction word, valid 2 cycles after imem_addr_out is presented.
- imem_addr_out  out  32  byte address of the instruction; always equals PC. The RAM uses bits [15:2].
- dmem_addr_out  out  32  word-aligned data address (effective address with [1:0] cleared).
- dmem_data_out  out  32  store data, already shifted into byte lanes.
- dmem_write_enable_out  out  4  per-byte write strobe; bit i writes bits [8i+7:8i].
- dmem_data_in  in  32  load word, valid 2 cycles after the address is presented.

## Operation
- Register file: x0–x31, 32 bits each. x0 reads 0 and ignores writes. All registers clear to 0 on reset.
- States:
  - FETCH: advances to WAIT only if cpu_step_in=1, otherwise stays.
  - WAIT: always advances to EXEC.
  - EXEC: loads go to LD_WAIT; every other instruction goes to FETCH.
  - LD_WAIT: advances to LD_WB.
  - LD_WB: advances to FETCH.
- Instruction source: imem_addr_out is held at PC in every state, so imem_data_in is valid throughout EXEC and decoded combinationally there.
- EXEC, non-load instructions: rd write-back and PC update happen on the edge that leaves EXEC.
  - LUI, AUIPC.
  - JAL, JALR: rd=PC+4. JALR target is (rs1+imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: PC = PC+imm if taken, else PC+4.
  - OP-IMM and OP, full RV32I ALU. Shift amount is the low 5 bits. SRA/SRAI are arithmetic. SLT is signed, SLTU is unsigned.
  - All other instructions, including FENCE, ECALL, EBREAK, CSR and illegal opcodes: no-op, PC=PC+4.
- Effective address: EA = rs1 + sign-extended imm, modulo 2^32. Let off = EA[1:0].
- Stores, only in EXEC, for exactly one cycle:
  - dmem_addr_out = {EA[31:2],2'b00}.
  - SB: data = {4{rs2[7:0]}}, strobe = 4'b0001<<off.
  - SH: data = {2{rs2[15:0]}}, strobe = 4'b0011<<{off[1],1'b0}. off[0] is ignored.
  - SW: data = rs2, strobe = 4'b1111. off is ignored.
- Loads:
  - EXEC presents {EA[31:2],2'b00}. The address is registered and held through LD_WAIT and LD_WB.
  - In LD_WB, extract from dmem_data_in: LB/LBU use byte off; LH/LHU use the half selected by off[1]; LW uses the whole word.
  - LB/LH sign-extend, LBU/LHU zero-extend. Write rd and set PC=PC+4.
- Misalignment never traps. A misaligned PC target is accepted as-is; the RAM ignores bits [1:0].
- Idle outputs: outside store EXEC and load states, dmem_addr_out=0, dmem_data_out=0, dmem_write_enable_out=0.
- Memories: both RAMs are read-first. A read and write to the same word in the same cycle returns the old data. Instruction memory is never written by the core.

## Timing
- Reset: rst_in=1 on an edge sets state=FETCH, PC=RESET_PC and clears all registers.
  - While rst_in=1, dmem_write_enable_out is forced to 0 combinationally, including mid-store.
  - Reset in any state abandons the instruction in progress with no register write.
- Cycles per instruction, with cpu_step_in=1 at FETCH:
  - Non-load: 3 cycles (FETCH, WAIT, EXEC).
  - Load: 5 cycles.
  - Each cycle cpu_step_in=0 in FETCH adds one cycle.
- cpu_step_in is sampled only in FETCH. Once an instruction starts, it completes regardless of step.
- Store strobe is asserted exactly 1 cycle per store instruction, never in any other state.
- Back-to-back: a load may read a word stored by the immediately preceding instruction. The store commits at the end of EXEC, before the load's address cycle.

## Test plan
- Reset then step: rst_in=1 for 1 cycle, cpu_step_in held 1, program `addi x1,x0,5; addi x2,x1,-7`.
  - After reset: imem_addr_out=0, we=0.
  - After 6 cycles: x1=5, x2=32'hFFFFFFFE, PC=8.
- Step gating: hold cpu_step_in=0 for 10 cycles.
  - State stays in FETCH, PC unchanged, no strobes.
  - Random cpu_step_in: final architectural state matches step=1 run after equal instruction count.
- Store/load lanes, x5=32'h1000, x6=32'hA1B2C3D4:
  - `sb x6,1(x5)` → addr=32'h1000, strobe=4'b0010, data=32'hD4D4D4D4.
  - `sh x6,2(x5)` → strobe=4'b1100.
  - Then `lw x7,0(x5)` → x7=32'hC3D4D400 (word previously zero).
  - `lb x8,1(x5)` → 32'hFFFFFFD4; `lbu` → 32'h000000D4.
- Branch/jump:
  - `beq x0,x0,-8` at PC=16 → PC=8.
  - `bltu` with x1=-1, x2=1 → not taken.
  - `jalr x1,3(x0)` at PC=20 → PC=2, x1=24.
- ALU edges:
  - `sra` of 32'h80000000 by 31 → 32'hFFFFFFFF.
  - `slt` with -1 vs 1 → 1; `sltu` → 0.
  - `add` 32'hFFFFFFFF+1 → 0.
  - Write to x0 leaves x0=0.
- Reset mid-store: assert rst_in during the EXEC cycle of `sw`.
  - Strobe=0 that cycle, memory unchanged, PC=RESET_PC.
